// File: rtl/slt_serial_n_bit_if.sv
// ============================================================================
// Module      : slt_serial_n_bit_if
// Description : Start/operand/result bundle for the bit-serial set-less-than
//               engine. Master drives the request, slave returns the results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slt_serial_n_bit_if #(
  parameter int WORD_SIZE = 32
);
  logic                 start;
  logic [WORD_SIZE-1:0] R2;
  logic [WORD_SIZE-1:0] R3;
  logic                 busy;
  logic                 done;
  logic                 SLT_out;
  logic                 SLTU_out;
  logic                 EQ_out;

  modport master (
    output start, R2, R3,
    input  busy, done, SLT_out, SLTU_out, EQ_out
  );

  modport slave (
    input  start, R2, R3,
    output busy, done, SLT_out, SLTU_out, EQ_out
  );
endinterface

`default_nettype wire

// File: rtl/slt_serial_n_bit.sv
// ============================================================================
// Module      : slt_serial_n_bit
// Description : Bit-serial signed/unsigned set-less-than, LSB first, computing
//               R2 + ~R3 + 1 one bit per clock. Define SLT_SERIAL_EQ_EN to
//               include the equality accumulator (EQ_out tied 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slt_serial_n_bit #(
  parameter int WORD_SIZE = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  slt_serial_n_bit_if.slave  bus
);

  localparam int             CW      = $clog2(WORD_SIZE);
  localparam logic [CW-1:0]  c_last  = CW'(WORD_SIZE - 1);
  localparam logic [1:0]     S_IDLE  = 2'd0;
  localparam logic [1:0]     S_RUN   = 2'd1;
  localparam logic [1:0]     S_DONE  = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  logic                 r_a_msb;
  logic                 r_b_msb;
  logic                 r_carry;
  logic                 r_slt;
  logic                 r_sltu;
  logic                 w_eq;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_d;
  logic                 w_carry_nxt;
  logic                 w_ovf;

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_last      = (r_state == S_RUN) && (r_cnt == c_last);

  // One full-adder slice of R2 + ~R3 + carry on the current LSBs
  assign w_d         = r_a[0] ^ ~r_b[0] ^ r_carry;
  assign w_carry_nxt = (r_a[0] & ~r_b[0]) | (r_carry & (r_a[0] ^ ~r_b[0]));
  assign w_ovf       = (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_carry <= 1'b1;
      r_slt   <= 1'b0;
      r_sltu  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.R2;
      r_b     <= bus.R3;
      r_a_msb <= bus.R2[WORD_SIZE-1];
      r_b_msb <= bus.R3[WORD_SIZE-1];
      r_carry <= 1'b1;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= {1'b0, r_a[WORD_SIZE-1:1]};
      r_b     <= {1'b0, r_b[WORD_SIZE-1:1]};
      r_carry <= w_carry_nxt;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_slt  <= w_d ^ w_ovf;
        r_sltu <= ~w_carry_nxt;
      end
    end
  end

`ifdef SLT_SERIAL_EQ_EN
  logic r_zero;
  logic r_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b1;
      r_eq   <= 1'b0;
    end else if (w_accept) begin
      r_zero <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_zero <= r_zero & ~w_d;
      if (w_last) r_eq <= r_zero & ~w_d;
    end
  end

  assign w_eq = r_eq;
`else
  assign w_eq = 1'b0;
`endif

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.SLT_out  = r_slt;
  assign bus.SLTU_out = r_sltu;
  assign bus.EQ_out   = w_eq;

endmodule

`default_nettype wire

// File: tb/tb_slt_serial_n_bit.sv
// ============================================================================
// Module      : tb_slt_serial_n_bit
// Description : Self-checking bench for slt_serial_n_bit against an arithmetic
//               reference (signed/unsigned compare, equality).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slt_serial_n_bit;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  slt_serial_n_bit_if #(.WORD_SIZE(W)) bus ();

  slt_serial_n_bit #(.WORD_SIZE(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic eq;
`ifdef SLT_SERIAL_EQ_EN
    eq = (a == b);
`else
    eq = 1'b0;
`endif
    return {($signed(a) < $signed(b)), (a < b), eq};
  endfunction

  // Drives one request, leaves the bench on the done cycle; lat=-1 on timeout
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    bus.start = 1'b1;
    bus.R2    = a;
    bus.R3    = b;
    tick();
    bus.start = 1'b0;
    bus.R2    = $urandom;
    bus.R3    = $urandom;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.R2    = '0;
    bus.R3    = '0;
    repeat (3) tick();
    got = {bus.busy, bus.done, bus.SLT_out, bus.SLTU_out, bus.EQ_out};
    n_checks++;
    if (got !== 5'b0) $display("FAIL reset_outputs got=%b exp=%b", got, 5'b0);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic [2:0]   exp;
    logic [2:0]   got;
    int           lat;
    va = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
           32'h0000_1234, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF};
    vb = '{32'd7, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000,
           32'h0000_1234, 32'd0, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], lat);
      n_checks++;
      if (lat !== W) $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, W);
      else n_pass++;
      exp = ref_model(va[i], vb[i]);
      got = {bus.SLT_out, bus.SLTU_out, bus.EQ_out};
      n_checks++;
      if (got !== exp) $display("FAIL dir_result[%0d] a=%h b=%h got=%b exp=%b", i, va[i], vb[i], got, exp);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.done, bus.busy} !== 2'b00)
        $display("FAIL dir_done_fall[%0d] got=%b exp=00", i, {bus.done, bus.busy});
      else n_pass++;
      n_checks++;
      if ({bus.SLT_out, bus.SLTU_out, bus.EQ_out} !== exp)
        $display("FAIL dir_hold[%0d] got=%b exp=%b", i, {bus.SLT_out, bus.SLTU_out, bus.EQ_out}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   exp;
    logic [2:0]   got;
    int           lat;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = (i % 6 == 0) ? a : $urandom;
      if (i % 4 == 1) b = {~a[W-1], b[W-2:0]};
      do_op(a, b, lat);
      exp = ref_model(a, b);
      got = {bus.SLT_out, bus.SLTU_out, bus.EQ_out};
      n_checks++;
      if (lat !== W || got !== exp)
        $display("FAIL rand[%0d] a=%h b=%h lat=%0d got=%b exp=%b", i, a, b, lat, got, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    logic [2:0] exp;
    logic [2:0] got;
    int         lat;
    int         cyc;
    exp = ref_model(32'd5, 32'd7);
    bus.start = 1'b1;
    bus.R2    = 32'd5;
    bus.R3    = 32'd7;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      bus.start = (cyc == 10);
      bus.R2    = 32'd9;
      bus.R3    = 32'd1;
      tick();
      if (bus.done) begin
        lat = cyc;
        break;
      end
    end
    n_checks++;
    if (lat !== W) $display("FAIL busy_latency got=%0d exp=%0d", lat, W);
    else n_pass++;
    got = {bus.SLT_out, bus.SLTU_out, bus.EQ_out};
    n_checks++;
    if (got !== exp) $display("FAIL busy_result got=%b exp=%b", got, exp);
    else n_pass++;
    // Request during DONE must be dropped: IDLE follows, no new RUN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL done_start_ignored busy=%b exp=0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    logic [2:0] got;
    int         gap;
    logic       seen_idle;
    bus.start = 1'b1;
    bus.R2    = 32'hFFFF_FFFF;
    bus.R3    = 32'h0000_0001;
    tick();
    bus.R2    = 32'h0000_0001;
    bus.R3    = 32'hFFFF_FFFF;
    exp       = ref_model(32'h0000_0001, 32'hFFFF_FFFF);
    gap       = -1;
    seen_idle = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (!bus.busy) seen_idle = 1'b1;
      else if (seen_idle) begin
        gap = k;
        break;
      end
    end
    n_checks++;
    if (gap !== W + 2) $display("FAIL b2b_interval got=%0d exp=%0d", gap, W + 2);
    else n_pass++;
    bus.start = 1'b0;
    for (int k = 0; k < 40 && !bus.done; k++) tick();
    got = {bus.SLT_out, bus.SLTU_out, bus.EQ_out};
    n_checks++;
    if (got !== exp || bus.done !== 1'b1) $display("FAIL b2b_second_result got=%b done=%b exp=%b", got, bus.done, exp);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [4:0] got;
    logic [2:0] exp;
    logic [2:0] res;
    logic       saw_done;
    int         lat;
    bus.start = 1'b1;
    bus.R2    = 32'hFFFF_FFFF;
    bus.R3    = 32'h0000_0002;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    got = {bus.busy, bus.done, bus.SLT_out, bus.SLTU_out, bus.EQ_out};
    n_checks++;
    if (got !== 5'b0) $display("FAIL midrun_reset_outputs got=%b exp=00000", got);
    else n_pass++;
    tick();
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL midrun_no_done got=%b exp=0", saw_done);
    else n_pass++;
    do_op(32'h8000_0000, 32'h7FFF_FFFF, lat);
    exp = ref_model(32'h8000_0000, 32'h7FFF_FFFF);
    res = {bus.SLT_out, bus.SLTU_out, bus.EQ_out};
    n_checks++;
    if (lat !== W || res !== exp) $display("FAIL post_reset_op lat=%0d got=%b exp=%b", lat, res, exp);
    else n_pass++;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slt_serial_n_bit.md
# slt_serial_n_bit

Multi-cycle, bit-serial set-less-than engine for the ALU_REG datapath. It latches two word_size operands on a start handshake and computes R2 − R3 one bit per clock, LSB first, as R2 + ~R3 + 1. It returns the signed less-than result, the unsigned less-than result and, optionally, an equality flag. It is the sequential, area-minimal counterpart to the combinational subtract-based compare path and serves slow or shared ALU slots.

## Interface
- word_size, 32, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- R2  input  word_size  minuend operand, captured on accepted start
- R3  input  word_size  subtrahend operand, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; results valid from this cycle on
- SLT_out  output  1  1 when R2 < R3 as signed two's complement
- SLTU_out  output  1  1 when R2 < R3 as unsigned
- EQ_out  output  1  1 when R2 == R3 (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Bit counter is clog2(word_size) bits wide.
- Reset (async, rst_n=0):
  - state=IDLE; counter=0; carry=1; zero-accumulator=1.
  - busy=0, done=0, SLT_out=0, SLTU_out=0, EQ_out=0.
- IDLE, start=1:
  - Load shift registers A←R2, B←R3.
  - Latch sign bits a_msb=R2[word_size-1] and b_msb=R3[word_size-1].
  - carry←1, zero←1, counter←0, go to RUN.
- IDLE, start=0: stay in IDLE. Result outputs hold their last values.
- RUN, each cycle:
  - d = A[0] ^ ~B[0] ^ carry.
  - carry ← (A[0] & ~B[0]) | (carry & (A[0] ^ ~B[0])).
  - zero ← zero & ~d.
  - A and B shift right by 1. counter increments.
- RUN, on the bit where counter == word_size-1:
  - d is the result MSB; the updated carry is the final carry-out.
  - Register SLT_out = d ^ ovf, with ovf = (a_msb ^ b_msb) & (d ^ a_msb).
  - Register SLTU_out = ~carry_out.
  - Register EQ_out = zero & ~d.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- start is ignored in RUN and DONE: no queuing, no effect on results.
- Result outputs change only on the DONE transition and hold until the next completion or reset.
- Reset asserted mid-RUN aborts the operation. Outputs return to reset values; no done pulse is produced.
- R2 and R3 may change freely after the accepting edge.

## Timing
- Start accepted at edge E0. Bits 0..word_size-1 are processed at edges E1..E_word_size.
- Results are registered and done rises at edge E_word_size. done falls at E_word_size+1.
- Latency is word_size cycles from the accepting edge to done. busy is high over the same window plus the DONE cycle.
- Minimum start-to-start interval is word_size+2 cycles. The earliest next accept is edge E_word_size+2, because start is not sampled in DONE.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SLT_SERIAL_EQ_EN defined: the zero-accumulator flop and its logic are compiled in, and EQ_out behaves as specified above.
- SLT_SERIAL_EQ_EN undefined: the accumulator is removed and EQ_out is tied to 0. The port remains, and all other behaviour and timing are unchanged.

## Test plan
All scenarios use word_size=32 and SLT_SERIAL_EQ_EN defined unless noted.
- R2=5, R3=7, start → done exactly 32 cycles after the accept edge; SLT_out=1, SLTU_out=1, EQ_out=0.
- R2=0xFFFFFFFF, R3=0x00000001 → SLT_out=1, SLTU_out=0, EQ_out=0.
- R2=0x80000000, R3=0x7FFFFFFF (overflow case) → SLT_out=1, SLTU_out=0. Swapped operands → SLT_out=0, SLTU_out=1.
- R2=R3=0x00001234 → SLT_out=0, SLTU_out=0, EQ_out=1. With the macro undefined → EQ_out=0.
- Back-to-back and busy handling:
  - Assert start at cycle 10 of RUN with different operands → ignored; the first result is unaffected.
  - Assert start during DONE → ignored.
  - Hold start continuously → next accept occurs 34 cycles after the first.
- Drop rst_n at cycle 15 of RUN → all outputs 0 immediately, no done pulse. The next start after release completes normally.
